// File: rtl/lsu_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_axi_pkg
// Purpose  : Shared types and constants for the LSU AXI write-response slave:
//            FSM state encoding, BRESP / AxBURST codes and the byte-lane
//            offsets of the two registers in the 8-byte window.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package lsu_axi_pkg;

    // Write-channel FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } wr_state_t;

    // BRESP codes
    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;

    // AxBURST codes
    localparam logic [1:0] BURST_FIXED  = 2'b00;
    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [1:0] BURST_WRAP   = 2'b10;

    // Only full 64-bit beats are supported
    localparam logic [2:0] AXSIZE_64B   = 3'd3;

    // Register offsets, expressed as the first byte lane of each register
    localparam int REG_GPIO_LANE = 0;
    localparam int REG_LA_LANE   = 4;

    // Implemented width of GPIO_DATA
    localparam int GPIO_W = 28;

endpackage : lsu_axi_pkg
`default_nettype wire

// File: rtl/axi_strb_merge.sv
`default_nettype none
// ============================================================================
// Module   : axi_strb_merge
// Purpose  : Byte-strobe merge of new write data into a 32-bit register
//            value. Each byte lane takes the new byte when its strobe is set,
//            otherwise keeps the current byte. Purely combinational.
// Ports    : i_cur    [31:0] current register value
//            i_wdata  [31:0] write data for this register's lanes
//            i_strb   [3:0]  byte strobes for this register's lanes
//            o_merged [31:0] merged value
// Revision : 1.0 - initial release
// ============================================================================
module axi_strb_merge (
    input  logic [31:0] i_cur,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_strb,
    output logic [31:0] o_merged
);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign o_merged[8*g +: 8] = i_strb[g] ? i_wdata[8*g +: 8] : i_cur[8*g +: 8];
    end

endmodule : axi_strb_merge
`default_nettype wire

// File: rtl/lsu_axi_wr_resp.sv
`default_nettype none
// ============================================================================
// Module   : lsu_axi_wr_resp
// Purpose  : AXI write-only slave for the LSU bus exposing an 8-byte register
//            window: GPIO_DATA (lanes 0-3, 28 bits) and LA_DATA (lanes 4-7).
//            Accepts one burst at a time (AW, then W beats, then B).
// Ports    : wb_clk_i / wb_rst_i      clock, synchronous active-high reset
//            lsu_axi_aw*              write address channel
//            lsu_axi_w*               write data channel
//            lsu_axi_b*               write response channel
//            gpio_out [27:0]          GPIO_DATA register
//            la_out   [31:0]          LA_DATA register
//            wr_pulse                 one-cycle strobe after a register update
// Revision : 1.0 - initial release
// ============================================================================
module lsu_axi_wr_resp
    import lsu_axi_pkg::*;
#(
    parameter int          ID_W      = 3,
    parameter logic [31:0] BASE_ADDR = 32'hD000_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    // AW
    input  logic              lsu_axi_awvalid,
    input  logic [ID_W-1:0]   lsu_axi_awid,
    input  logic [31:0]       lsu_axi_awaddr,
    input  logic [7:0]        lsu_axi_awlen,
    input  logic [2:0]        lsu_axi_awsize,
    input  logic [1:0]        lsu_axi_awburst,
    output logic              lsu_axi_awready,
    // W
    input  logic              lsu_axi_wvalid,
    input  logic [63:0]       lsu_axi_wdata,
    input  logic [7:0]        lsu_axi_wstrb,
    input  logic              lsu_axi_wlast,
    output logic              lsu_axi_wready,
    // B
    output logic              lsu_axi_bvalid,
    output logic [1:0]        lsu_axi_bresp,
    output logic [ID_W-1:0]   lsu_axi_bid,
    input  logic              lsu_axi_bready,
    // Registers
    output logic [GPIO_W-1:0] gpio_out,
    output logic [31:0]       la_out,
    output logic              wr_pulse
);

    wr_state_t          r_state;
    wr_state_t          w_state_nxt;

    logic [ID_W-1:0]    r_id;
    logic [31:0]        r_addr;
    logic [7:0]         r_len;
    logic [1:0]         r_burst;
    logic [7:0]         r_beat;
    logic               r_illegal;
    logic               r_err;
    logic [1:0]         r_bresp;
    logic [GPIO_W-1:0]  r_gpio;
    logic [31:0]        r_la;
    logic               r_wr_pulse;

    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_illegal_aw;
    logic               w_in_window;
    logic               w_is_last;
    logic               w_last_mismatch;
    logic               w_beat_end;
    logic               w_beat_we;
    logic               w_err_nxt;
    logic [31:0]        w_gpio_merged;
    logic [31:0]        w_la_merged;
    logic [3:0]         w_unused_gpio_hi;

    assign w_aw_hs         = lsu_axi_awvalid && lsu_axi_awready;
    assign w_w_hs          = lsu_axi_wvalid && lsu_axi_wready;

    assign w_illegal_aw    = (lsu_axi_awsize != AXSIZE_64B) || (lsu_axi_awburst == BURST_WRAP);
    assign w_in_window     = (r_addr[31:3] == BASE_ADDR[31:3]);
    assign w_is_last       = (r_beat == r_len);
    assign w_last_mismatch = (lsu_axi_wlast != w_is_last);
    // An early wlast terminates the burst at this beat.
    assign w_beat_end      = w_is_last || lsu_axi_wlast;
    assign w_beat_we       = w_in_window && !r_illegal;
    assign w_err_nxt       = r_err || !w_in_window || w_last_mismatch;

    // ------------------------------------------------------------------------
    // Byte-lane merge, one instance per 32-bit register
    // ------------------------------------------------------------------------
    axi_strb_merge u_merge_gpio (
        .i_cur    ({{(32-GPIO_W){1'b0}}, r_gpio}),
        .i_wdata  (lsu_axi_wdata[8*REG_GPIO_LANE +: 32]),
        .i_strb   (lsu_axi_wstrb[REG_GPIO_LANE +: 4]),
        .o_merged (w_gpio_merged)
    );

    axi_strb_merge u_merge_la (
        .i_cur    (r_la),
        .i_wdata  (lsu_axi_wdata[8*REG_LA_LANE +: 32]),
        .i_strb   (lsu_axi_wstrb[REG_LA_LANE +: 4]),
        .o_merged (w_la_merged)
    );

    // GPIO_DATA only implements 28 bits; the top nibble of its lanes is dropped.
    assign w_unused_gpio_hi = w_gpio_merged[31:GPIO_W];

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and channel ready/valid. Handshake outputs are gated by
    // reset so nothing is accepted or offered while reset is asserted.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        lsu_axi_awready = 1'b0;
        lsu_axi_wready  = 1'b0;
        lsu_axi_bvalid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                lsu_axi_awready = !wb_rst_i;
                if (w_aw_hs) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                lsu_axi_wready = !wb_rst_i;
                if (w_w_hs && w_beat_end) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                lsu_axi_bvalid = !wb_rst_i;
                if (lsu_axi_bready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Burst context, error tracking and register file
    // ------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_id       <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_burst    <= '0;
            r_beat     <= '0;
            r_illegal  <= 1'b0;
            r_err      <= 1'b0;
            r_bresp    <= BRESP_OKAY;
            r_gpio     <= '0;
            r_la       <= '0;
            r_wr_pulse <= 1'b0;
        end else begin
            r_wr_pulse <= 1'b0;

            if (w_aw_hs) begin
                r_id      <= lsu_axi_awid;
                r_addr    <= lsu_axi_awaddr;
                r_len     <= lsu_axi_awlen;
                r_burst   <= lsu_axi_awburst;
                r_beat    <= '0;
                r_illegal <= w_illegal_aw;
                r_err     <= w_illegal_aw;
            end

            if (w_w_hs) begin
                r_beat <= r_beat + 8'd1;
                if (r_burst != BURST_FIXED) begin
                    r_addr <= r_addr + 32'd8;
                end
                if (w_beat_we) begin
                    r_gpio     <= w_gpio_merged[GPIO_W-1:0];
                    r_la       <= w_la_merged;
                    r_wr_pulse <= 1'b1;
                end
                r_err <= w_err_nxt;
                if (w_beat_end) begin
                    r_bresp <= w_err_nxt ? BRESP_SLVERR : BRESP_OKAY;
                end
            end
        end
    end

    assign lsu_axi_bid   = r_id;
    assign lsu_axi_bresp = r_bresp;
    assign gpio_out      = r_gpio;
    assign la_out        = r_la;
    assign wr_pulse      = r_wr_pulse;

endmodule : lsu_axi_wr_resp
`default_nettype wire

// File: tb/tb_lsu_axi_wr_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_axi_wr_resp
// Purpose  : Self-checking bench for lsu_axi_wr_resp. Directed scenarios plus
//            randomized bursts compared against a transaction-level model of
//            the register window.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_axi_wr_resp;

    localparam int          ID_W = 3;
    localparam logic [31:0] BASE = 32'hD000_0000;

    logic            clk;
    logic            rst;
    logic            awvalid;
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awready;
    logic            wvalid;
    logic [63:0]     wdata;
    logic [7:0]      wstrb;
    logic            wlast;
    logic            wready;
    logic            bvalid;
    logic [1:0]      bresp;
    logic [ID_W-1:0] bid;
    logic            bready;
    logic [27:0]     gpio_out;
    logic [31:0]     la_out;
    logic            wr_pulse;

    lsu_axi_wr_resp #(.ID_W(ID_W), .BASE_ADDR(BASE)) dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .lsu_axi_awvalid (awvalid),
        .lsu_axi_awid    (awid),
        .lsu_axi_awaddr  (awaddr),
        .lsu_axi_awlen   (awlen),
        .lsu_axi_awsize  (awsize),
        .lsu_axi_awburst (awburst),
        .lsu_axi_awready (awready),
        .lsu_axi_wvalid  (wvalid),
        .lsu_axi_wdata   (wdata),
        .lsu_axi_wstrb   (wstrb),
        .lsu_axi_wlast   (wlast),
        .lsu_axi_wready  (wready),
        .lsu_axi_bvalid  (bvalid),
        .lsu_axi_bresp   (bresp),
        .lsu_axi_bid     (bid),
        .lsu_axi_bready  (bready),
        .gpio_out        (gpio_out),
        .la_out          (la_out),
        .wr_pulse        (wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of the register window
    logic [27:0] m_gpio;
    logic [31:0] m_la;
    int          m_pulses;

    // Per-beat stimulus for the next burst
    logic [63:0] beat_data [256];
    logic [7:0]  beat_strb [256];
    bit          beat_last [256];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_awready"}, awready, 0);
        check({tag, "_wready"},  wready,  0);
        check({tag, "_bvalid"},  bvalid,  0);
        check({tag, "_bresp"},   bresp,   0);
        check({tag, "_bid"},     bid,     0);
        check({tag, "_gpio"},    gpio_out, 0);
        check({tag, "_la"},      la_out,  0);
        check({tag, "_pulse"},   wr_pulse, 0);
    endtask

    // Default last pattern: wlast only on beat len
    task automatic set_lasts(input int len);
        for (int i = 0; i < 256; i++) beat_last[i] = (i == len);
    endtask

    // One complete AXI write. Called and returns on a negedge.
    // early_cycles: W presented this many cycles before AW.
    // abort_after : assert reset after this many accepted beats (0 = never).
    task automatic run_write(input logic [ID_W-1:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int early_cycles,
                             input int bready_delay, input int abort_after);
        bit          legal, inwin, we, err, exp_last;
        logic [31:0] a;
        logic [63:0] cur;
        logic [1:0]  exp_resp;
        int          guard;

        legal    = (size == 3'd3) && (burst != 2'b10);
        err      = !legal;
        a        = addr;
        m_pulses = 0;

        if (early_cycles > 0) begin
            wvalid = 1'b1; wdata = beat_data[0]; wstrb = beat_strb[0]; wlast = beat_last[0];
            for (int c = 0; c < early_cycles; c++) begin
                @(negedge clk);
                check("early_wready", wready, 0);
                check("early_pulse", wr_pulse, 0);
                check("early_gpio", gpio_out, m_gpio);
                check("early_la", la_out, m_la);
            end
        end

        awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
        guard = 0;
        while (!awready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!awready) begin
            check("aw_wait", awready, 1);
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        @(negedge clk);
        awvalid = 1'b0;

        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1; wdata = beat_data[i]; wstrb = beat_strb[i]; wlast = beat_last[i];
            guard = 0;
            while (!wready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (!wready) begin
                check("w_wait", wready, 1);
                wvalid = 1'b0;
                return;
            end
            inwin    = (a[31:3] == BASE[31:3]);
            we       = legal && inwin;
            exp_last = (i == int'(len));
            if (!inwin) err = 1'b1;
            if (beat_last[i] != exp_last) err = 1'b1;
            if (we) begin
                cur = {m_la, 4'h0, m_gpio};
                for (int b = 0; b < 8; b++)
                    if (beat_strb[i][b]) cur[8*b +: 8] = beat_data[i][8*b +: 8];
                m_la   = cur[63:32];
                m_gpio = cur[27:0];
            end
            @(negedge clk);
            check("beat_pulse", wr_pulse, we);
            check("beat_gpio", gpio_out, m_gpio);
            check("beat_la", la_out, m_la);
            if (wr_pulse) m_pulses++;
            if (burst != 2'b00) a = a + 32'd8;

            if (abort_after == i + 1) begin
                wvalid = 1'b0; wlast = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                check_all_zero("rst_mid");
                rst = 1'b0;
                m_gpio = '0; m_la = '0;
                @(negedge clk);
                check("rst_mid_awready", awready, 1);
                check("rst_mid_nob", bvalid, 0);
                return;
            end
            if (beat_last[i] || exp_last) break;
        end
        wvalid = 1'b0; wlast = 1'b0;

        exp_resp = err ? 2'b10 : 2'b00;
        check("b_valid", bvalid, 1);
        check("b_id", bid, id);
        check("b_resp", bresp, exp_resp);
        check("b_awready_lo", awready, 0);
        for (int c = 0; c < bready_delay; c++) begin
            @(negedge clk);
            check("bhold_valid", bvalid, 1);
            check("bhold_id", bid, id);
            check("bhold_resp", bresp, exp_resp);
            check("bhold_awready", awready, 0);
        end
        bready = 1'b1;
        check("b_hs_awready", awready, 0);
        @(negedge clk);
        bready = 1'b0;
        check("b_done_valid", bvalid, 0);
        check("b_done_awready", awready, 1);
        check("b_done_gpio", gpio_out, m_gpio);
        check("b_done_la", la_out, m_la);
    endtask

    initial begin
        logic [7:0]  r_len;
        logic [31:0] r_addr;
        logic [1:0]  r_burst;
        logic [2:0]  r_size;

        rst = 1'b1; awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0; awsize = '0;
        awburst = '0; wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b0;
        m_gpio = '0; m_la = '0; m_pulses = 0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_awready", awready, 1);

        // Single full write
        beat_data[0] = 64'h0000_00AB_0123_4567; beat_strb[0] = 8'hFF; set_lasts(0);
        run_write(3'd5, BASE, 8'd0, 3'd3, 2'b01, 0, 0, 0);
        check("single_gpio", gpio_out, 28'h0123_4567);
        check("single_la", la_out, 32'h0000_00AB);

        // Partial strobe
        beat_data[0] = 64'hFFFF_FFFF_FFFF_FFFF; beat_strb[0] = 8'h0F;
        run_write(3'd1, BASE, 8'd0, 3'd3, 2'b01, 0, 0, 0);
        check("prefill_gpio", gpio_out, 28'h0FFF_FFFF);
        beat_data[0] = 64'h0; beat_strb[0] = 8'h01;
        run_write(3'd2, BASE, 8'd0, 3'd3, 2'b01, 0, 1, 0);
        check("partial_gpio", gpio_out, 28'h0FFF_FF00);
        check("partial_la", la_out, 32'h0000_00AB);

        // Out of window
        beat_data[0] = 64'h1234_5678_9ABC_DEF0; beat_strb[0] = 8'hFF;
        run_write(3'd3, BASE + 32'd16, 8'd0, 3'd3, 2'b01, 0, 0, 0);
        check("oow_pulses", m_pulses, 0);
        check("oow_gpio", gpio_out, 28'h0FFF_FF00);

        // FIXED burst of four beats into LA_DATA
        for (int i = 0; i < 4; i++) begin
            beat_data[i] = {32'(i + 1), 32'h0}; beat_strb[i] = 8'hF0;
        end
        set_lasts(3);
        run_write(3'd6, BASE, 8'd3, 3'd3, 2'b00, 0, 2, 0);
        check("burst_la", la_out, 32'd4);
        check("burst_pulses", m_pulses, 4);

        // Early W plus B backpressure
        beat_data[0] = 64'hCAFE_F00D_0BAD_BEEF; beat_strb[0] = 8'hFF; set_lasts(0);
        run_write(3'd7, BASE, 8'd0, 3'd3, 2'b01, 3, 5, 0);

        // Reset after the first beat of a four-beat burst, then a clean write
        for (int i = 0; i < 4; i++) begin
            beat_data[i] = {$urandom, $urandom}; beat_strb[i] = 8'hFF;
        end
        set_lasts(3);
        run_write(3'd4, BASE, 8'd3, 3'd3, 2'b01, 0, 0, 1);
        beat_data[0] = 64'h0000_0055_0AAA_AAAA; beat_strb[0] = 8'hFF; set_lasts(0);
        run_write(3'd2, BASE, 8'd0, 3'd3, 2'b00, 0, 0, 0);
        check("after_rst_gpio", gpio_out, 28'h0AAA_AAAA);
        check("after_rst_la", la_out, 32'h55);

        // 256-beat FIXED burst
        for (int i = 0; i < 256; i++) begin
            beat_data[i] = {$urandom, $urandom}; beat_strb[i] = 8'($urandom);
        end
        set_lasts(255);
        run_write(3'd1, BASE, 8'd255, 3'd3, 2'b00, 0, 0, 0);

        // Randomized bursts
        for (int t = 0; t < 60; t++) begin
            r_len = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(4, 9)) : 8'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: r_addr = BASE;
                1: r_addr = BASE + 32'd4;
                2: r_addr = BASE + 32'd8;
                3: r_addr = BASE - 32'd8;
                4: r_addr = BASE + 32'd16;
                default: r_addr = $urandom;
            endcase
            r_burst = 2'($urandom_range(0, 2));
            r_size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 2)) : 3'd3;
            for (int i = 0; i <= int'(r_len); i++) begin
                beat_data[i] = {$urandom, $urandom}; beat_strb[i] = 8'($urandom);
            end
            set_lasts(int'(r_len));
            case ($urandom_range(0, 7))
                0: if (r_len > 0) beat_last[$urandom_range(0, int'(r_len) - 1)] = 1'b1;
                1: beat_last[r_len] = 1'b0;
                default: ;
            endcase
            run_write(3'($urandom), r_addr, r_len, r_size, r_burst,
                      ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0,
                      int'($urandom_range(0, 3)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_lsu_axi_wr_resp
`default_nettype wire
